// File: rtl/apb_bridge_pkg.sv
// Shared state encoding and response codes for the multi-slave AHB-to-APB bridge.
package apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WLATCH = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  localparam logic [1:0]  HRESP_OKAY   = 2'b00;
  localparam logic [1:0]  HRESP_ERROR  = 2'b01;
  localparam logic [39:0] DEFAULT_MASK = 40'hFF_FFFF_F000;

endpackage

// File: rtl/apb_addr_decode.sv
// Base/mask address decoder; the lowest-numbered matching slave wins on overlap.
module apb_addr_decode #(
  parameter int NSLV   = 8,
  parameter int ADDR_W = 40
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic [NSLV*ADDR_W-1:0] slv_base,
  input  logic [NSLV*ADDR_W-1:0] slv_mask,
  output logic [NSLV-1:0]        hit,
  output logic                   miss
);

  always_comb begin
    hit  = '0;
    miss = 1'b1;
    for (int i = 0; i < NSLV; i++) begin
      if (miss && ((addr & slv_mask[i*ADDR_W +: ADDR_W]) == slv_base[i*ADDR_W +: ADDR_W])) begin
        hit[i] = 1'b1;
        miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/apb_bridge_multi.sv
// AHB-to-APB bridge for NSLV APB3 slaves with wait states, slave errors,
// unmapped-address errors and a PREADY timeout, all reported as a two-cycle ERROR.
//
// state  | meaning
// IDLE   | ready for a new AHB request
// WLATCH | write accepted, waiting one cycle for the AHB data phase
// SETUP  | APB setup phase, psel high, penable low
// ACCESS | APB access phase, waiting for pready or timeout
// ERR1   | first ERROR cycle for an unmapped address (hready low)
// ERR2   | second ERROR cycle (hready high)
module apb_bridge_multi
  import apb_bridge_pkg::*;
#(
  parameter int                      NSLV     = 8,
  parameter int                      ADDR_W   = 40,
  parameter int                      DATA_W   = 32,
  parameter logic [NSLV*ADDR_W-1:0]  SLV_BASE = {NSLV{ADDR_W'(0)}},
  parameter logic [NSLV*ADDR_W-1:0]  SLV_MASK = {NSLV{ADDR_W'(DEFAULT_MASK)}},
  parameter int                      TIMEOUT  = 255
) (
  input  logic                   hclk,
  input  logic                   hrst,
  input  logic                   harb_apb_hsel,
  input  logic [ADDR_W-1:0]      harb_xx_haddr,
  input  logic                   harb_xx_hwrite,
  input  logic [DATA_W-1:0]      harb_xx_hwdata,
  output logic [DATA_W-1:0]      apb_harb_hrdata,
  output logic                   apb_harb_hready,
  output logic [1:0]             apb_harb_hresp,
  output logic [ADDR_W-1:0]      apb_xx_paddr,
  output logic                   apb_xx_pwrite,
  output logic [DATA_W-1:0]      apb_xx_pwdata,
  output logic                   apb_xx_penable,
  output logic [NSLV-1:0]        psel,
  input  logic [NSLV*DATA_W-1:0] prdata,
  input  logic [NSLV-1:0]        pready,
  input  logic [NSLV-1:0]        pslverr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic [NSLV-1:0]   hit_q;
  logic [NSLV-1:0]   dec_hit;
  logic              dec_miss;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rdata_sel;
  logic              rdy_sel;
  logic              err_sel;
  logic              in_access;
  logic              timeout_hit;
  logic              xfer_ok;
  logic              xfer_err;
  logic              accept;

  apb_addr_decode #(
    .NSLV   (NSLV),
    .ADDR_W (ADDR_W)
  ) u_decode (
    .addr     (harb_xx_haddr),
    .slv_base (SLV_BASE),
    .slv_mask (SLV_MASK),
    .hit      (dec_hit),
    .miss     (dec_miss)
  );

  // Slave-side signals are only meaningful for the slave latched at accept.
  always_comb begin
    rdata_sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (hit_q[i]) rdata_sel = rdata_sel | prdata[i*DATA_W +: DATA_W];
    end
  end

  assign rdy_sel     = |(pready & hit_q);
  assign err_sel     = |(pslverr & hit_q);
  assign in_access   = (state == ST_ACCESS);
  assign timeout_hit = (TIMEOUT != 0) && in_access && !rdy_sel && (cnt == TO_LAST);
  assign xfer_ok     = in_access && rdy_sel && !err_sel;
  assign xfer_err    = in_access && ((rdy_sel && err_sel) || timeout_hit);
  assign accept      = harb_apb_hsel && ((state == ST_IDLE) || xfer_ok);

  // The AHB response must follow pready within the ACCESS cycle to allow back-to-back accepts.
  assign apb_harb_hready = (state == ST_IDLE) || (state == ST_ERR2) || xfer_ok;
  assign apb_harb_hresp  = ((state == ST_ERR1) || (state == ST_ERR2) || xfer_err) ? HRESP_ERROR
                                                                                   : HRESP_OKAY;
  assign apb_harb_hrdata = (xfer_ok && !apb_xx_pwrite) ? rdata_sel : '0;

  always_ff @(posedge hclk) begin
    if (hrst) begin
      state          <= ST_IDLE;
      hit_q          <= '0;
      cnt            <= '0;
      apb_xx_paddr   <= '0;
      apb_xx_pwrite  <= 1'b0;
      apb_xx_pwdata  <= '0;
      apb_xx_penable <= 1'b0;
      psel           <= '0;
    end else if (accept) begin
      apb_xx_paddr   <= harb_xx_haddr;
      apb_xx_pwrite  <= harb_xx_hwrite;
      hit_q          <= dec_hit;
      apb_xx_penable <= 1'b0;
      if (dec_miss) begin
        state <= ST_ERR1;
        psel  <= '0;
      end else if (harb_xx_hwrite) begin
        state <= ST_WLATCH;
        psel  <= '0;
      end else begin
        state <= ST_SETUP;
        psel  <= dec_hit;
        cnt   <= '0;
      end
    end else begin
      case (state)
        ST_WLATCH: begin
          apb_xx_pwdata <= harb_xx_hwdata;
          psel          <= hit_q;
          cnt           <= '0;
          state         <= ST_SETUP;
        end
        ST_SETUP: begin
          apb_xx_penable <= 1'b1;
          state          <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (rdy_sel || timeout_hit) begin
            psel           <= '0;
            apb_xx_penable <= 1'b0;
            state          <= xfer_ok ? ST_IDLE : ST_ERR2;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_ERR1: state <= ST_ERR2;
        ST_ERR2: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_multi.sv
// Self-checking bench for apb_bridge_multi: directed scenarios plus randomized
// transactions checked against a transaction-level latency/response model.
module tb_apb_bridge_multi;

  localparam int NSLV = 8;
  localparam int AW   = 40;
  localparam int DW   = 32;
  localparam int TO   = 4;

  localparam logic [AW-1:0] BASE [NSLV] = '{
    40'h00_1001_0000, 40'h00_1001_3000, 40'h00_1001_1000, 40'h00_1001_2000,
    40'h00_1001_4000, 40'h00_1001_5000, 40'h00_1001_6000, 40'h00_1000_0000};
  localparam logic [AW-1:0] MASK [NSLV] = '{
    40'hFF_FFFF_F000, 40'hFF_FFFF_F000, 40'hFF_FFFF_F000, 40'hFF_FFFF_F000,
    40'hFF_FFFF_F000, 40'hFF_FFFF_F000, 40'hFF_FFFF_F000, 40'hFF_F000_0000};
  localparam logic [NSLV*AW-1:0] P_BASE = {BASE[7], BASE[6], BASE[5], BASE[4],
                                           BASE[3], BASE[2], BASE[1], BASE[0]};
  localparam logic [NSLV*AW-1:0] P_MASK = {MASK[7], MASK[6], MASK[5], MASK[4],
                                           MASK[3], MASK[2], MASK[1], MASK[0]};

  logic               hclk = 1'b0;
  logic               hrst;
  logic               hsel;
  logic [AW-1:0]      haddr;
  logic               hwrite;
  logic [DW-1:0]      hwdata;
  logic [DW-1:0]      hrdata;
  logic               hready;
  logic [1:0]         hresp;
  logic [AW-1:0]      paddr;
  logic               pwrite;
  logic [DW-1:0]      pwdata;
  logic               penable;
  logic [NSLV-1:0]    psel;
  logic [NSLV*DW-1:0] prdata;
  logic [NSLV-1:0]    pready;
  logic [NSLV-1:0]    pslverr;

  int vectors = 0;
  int miscompares = 0;

  apb_bridge_multi #(
    .NSLV(NSLV), .ADDR_W(AW), .DATA_W(DW),
    .SLV_BASE(P_BASE), .SLV_MASK(P_MASK), .TIMEOUT(TO)
  ) dut (
    .hclk(hclk), .hrst(hrst),
    .harb_apb_hsel(hsel), .harb_xx_haddr(haddr), .harb_xx_hwrite(hwrite), .harb_xx_hwdata(hwdata),
    .apb_harb_hrdata(hrdata), .apb_harb_hready(hready), .apb_harb_hresp(hresp),
    .apb_xx_paddr(paddr), .apb_xx_pwrite(pwrite), .apb_xx_pwdata(pwdata), .apb_xx_penable(penable),
    .psel(psel), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 hclk = ~hclk;

  // APB slave model: the selected slave answers after wait_cfg ACCESS cycles;
  // unselected slaves drive the opposite levels so a wrong slave mux shows up.
  logic [DW-1:0] slv_rdata [NSLV];
  int  wait_cfg;
  bit  err_cfg;
  int  acc_cnt = 0;

  always @(posedge hclk) acc_cnt <= (psel != '0 && penable) ? acc_cnt + 1 : 0;

  assign pready  = (acc_cnt >= wait_cfg) ? psel : ~psel;
  assign pslverr = err_cfg ? psel : ~psel;

  always_comb begin
    prdata = '0;
    for (int i = 0; i < NSLV; i++) prdata[i*DW +: DW] = slv_rdata[i];
  end

  // Reference model: decode rule and per-transaction expectations.
  int            e_lat, e_errc, e_pen, e_pscyc;
  logic [NSLV-1:0] e_psel;
  logic [DW-1:0] e_rdata;

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NSLV; i++) if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  task automatic model(input logic [AW-1:0] a, input bit w, input int waits, input bit err);
    int s, nacc;
    bit bad;
    s = decode(a);
    if (s < 0) begin
      e_lat = 3; e_errc = 2; e_pen = 0; e_pscyc = 0; e_psel = '0; e_rdata = '0;
    end else begin
      nacc    = (waits >= TO) ? TO : waits + 1;
      bad     = err || (waits >= TO);
      e_lat   = (w ? 2 : 1) + 1 + nacc + (bad ? 1 : 0);
      e_errc  = bad ? 2 : 0;
      e_pen   = nacc;
      e_pscyc = nacc + 1;
      e_psel  = NSLV'(1) << s;
      e_rdata = (bad || w) ? '0 : slv_rdata[s];
    end
  endtask

  // Transaction driver and observer.
  int              o_lat, o_errc, o_pen, o_pscyc;
  logic            o_req_hready, o_first_err_hready;
  logic [DW-1:0]   o_rdata, o_pwdata;
  logic [AW-1:0]   o_paddr;
  logic [NSLV-1:0] o_psel_or, o_psel_err, o_psel_after_err;
  bit              o_bad_sel;

  task automatic xfer(input logic [AW-1:0] a, input bit w, input logic [DW-1:0] d,
                      input int waits, input bit err, input bit keep_sel);
    bit seen_err, seen_setup;
    int err_c;
    @(posedge hclk); #1;
    wait_cfg = waits; err_cfg = err;
    hsel = 1'b1; haddr = a; hwrite = w;
    o_lat = -1; o_errc = 0; o_pen = 0; o_pscyc = 0; o_psel_or = '0; o_psel_err = '0;
    o_psel_after_err = '0; o_bad_sel = 0; o_rdata = '0; o_pwdata = '0; o_paddr = '0;
    o_first_err_hready = 1'b1;
    seen_err = 0; seen_setup = 0; err_c = 0;
    @(negedge hclk);
    o_req_hready = hready;
    for (int c = 1; c < 40; c++) begin
      @(posedge hclk); #1;
      hwdata = d;
      if (!keep_sel) begin
        hsel = 1'b0; haddr = {8'h0, $urandom()}; hwrite = 1'($urandom_range(0, 1));
      end
      @(negedge hclk);
      if (psel != '0) o_pscyc++;
      o_psel_or |= psel;
      if (penable) o_pen++;
      if ($countones(psel) > 1 || (penable && psel == '0)) o_bad_sel = 1;
      if (psel != '0 && !penable && !seen_setup) begin
        seen_setup = 1; o_pwdata = pwdata; o_paddr = paddr;
      end
      if (seen_err && c == err_c + 1) o_psel_after_err = psel;
      if (hresp == 2'b01) begin
        if (!seen_err) begin
          seen_err = 1; err_c = c; o_first_err_hready = hready; o_psel_err = psel;
        end
        o_errc++;
      end
      if (hready) begin
        o_lat = c + 1; o_rdata = hrdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(posedge hclk); @(posedge hclk); #1;
    @(negedge hclk);
    vectors++;
    if ({hready, hresp, hrdata} !== {1'b1, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_ahb: got hready=%b hresp=%b hrdata=%h exp 1 00 0", hready, hresp, hrdata);
    end
    vectors++;
    if ({psel, penable, paddr, pwrite, pwdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_apb: got psel=%h penable=%b paddr=%h pwrite=%b pwdata=%h exp all 0",
               psel, penable, paddr, pwrite, pwdata);
    end
    @(posedge hclk); #1; hrst = 1'b0;
  endtask

  task automatic test_read();
    slv_rdata[2] = 32'hA5A5_0001;
    xfer(40'h00_1001_1004, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    vectors++;
    if (o_req_hready !== 1'b1) begin
      miscompares++; $display("FAIL read_idle_hready: got %b exp 1", o_req_hready);
    end
    vectors++;
    if (o_lat !== 3 || o_rdata !== 32'hA5A5_0001 || o_errc !== 0) begin
      miscompares++;
      $display("FAIL read_basic: got lat=%0d rdata=%h errc=%0d exp 3 a5a50001 0", o_lat, o_rdata, o_errc);
    end
    vectors++;
    if (o_psel_or !== 8'h04 || o_pscyc !== 2 || o_pen !== 1 || o_paddr !== 40'h00_1001_1004) begin
      miscompares++;
      $display("FAIL read_apb: got psel=%h pscyc=%0d pen=%0d paddr=%h exp 04 2 1 0010011004",
               o_psel_or, o_pscyc, o_pen, o_paddr);
    end
  endtask

  task automatic test_write_wait();
    xfer(40'h00_1001_5010, 1'b1, 32'hDEAD_BEEF, 3, 1'b0, 1'b0);
    vectors++;
    if (o_pwdata !== 32'hDEAD_BEEF || o_pen !== 4 || o_psel_or !== 8'h20) begin
      miscompares++;
      $display("FAIL write_wait_apb: got pwdata=%h pen=%0d psel=%h exp deadbeef 4 20", o_pwdata, o_pen, o_psel_or);
    end
    vectors++;
    if (o_lat !== 7 || o_rdata !== 32'h0 || o_errc !== 0) begin
      miscompares++;
      $display("FAIL write_wait_ahb: got lat=%0d rdata=%h errc=%0d exp 7 0 0", o_lat, o_rdata, o_errc);
    end
  endtask

  task automatic test_unmapped();
    xfer(40'h00_2000_0000, 1'b0, 32'h0, 0, 1'b0, 1'b1);
    vectors++;
    if (o_lat !== 3 || o_errc !== 2 || o_first_err_hready !== 1'b0 || o_psel_or !== '0 || o_rdata !== '0) begin
      miscompares++;
      $display("FAIL unmapped: got lat=%0d errc=%0d hready1=%b psel=%h rdata=%h exp 3 2 0 00 0",
               o_lat, o_errc, o_first_err_hready, o_psel_or, o_rdata);
    end
    @(posedge hclk); #1; hsel = 1'b0;
    @(negedge hclk);
    vectors++;
    if (hready !== 1'b1 || hresp !== 2'b00 || psel !== '0) begin
      miscompares++;
      $display("FAIL err2_hsel_ignored: got hready=%b hresp=%b psel=%h exp 1 00 00", hready, hresp, psel);
    end
  endtask

  task automatic test_pslverr();
    xfer(40'h00_1001_5020, 1'b1, 32'h1234_5678, 1, 1'b1, 1'b0);
    vectors++;
    if (o_lat !== 6 || o_errc !== 2 || o_first_err_hready !== 1'b0) begin
      miscompares++;
      $display("FAIL pslverr_resp: got lat=%0d errc=%0d hready1=%b exp 6 2 0", o_lat, o_errc, o_first_err_hready);
    end
    vectors++;
    if (o_psel_err !== 8'h20 || o_psel_after_err !== 8'h00) begin
      miscompares++;
      $display("FAIL pslverr_psel: got err=%h after=%h exp 20 00", o_psel_err, o_psel_after_err);
    end
  endtask

  task automatic test_timeout();
    xfer(40'h00_1001_2000, 1'b0, 32'h0, 50, 1'b0, 1'b0);
    vectors++;
    if (o_lat !== 7 || o_pen !== 4 || o_errc !== 2 || o_first_err_hready !== 1'b0 || o_psel_after_err !== '0) begin
      miscompares++;
      $display("FAIL timeout: got lat=%0d pen=%0d errc=%0d hready1=%b psel_after=%h exp 7 4 2 0 00",
               o_lat, o_pen, o_errc, o_first_err_hready, o_psel_after_err);
    end
    slv_rdata[2] = 32'h0BAD_CAFE;
    xfer(40'h00_1001_1008, 1'b0, 32'h0, 0, 1'b0, 1'b0);
    vectors++;
    if (o_lat !== 3 || o_rdata !== 32'h0BAD_CAFE || o_errc !== 0) begin
      miscompares++;
      $display("FAIL after_timeout_read: got lat=%0d rdata=%h errc=%0d exp 3 0badcafe 0", o_lat, o_rdata, o_errc);
    end
  endtask

  task automatic test_back_to_back();
    slv_rdata[1] = 32'h1111_2222;
    wait_cfg = 0; err_cfg = 0;
    @(posedge hclk); #1; hsel = 1'b1; haddr = 40'h00_1001_3008; hwrite = 1'b0;
    @(posedge hclk); #1; haddr = 40'h00_1001_4010; hwrite = 1'b1;
    @(negedge hclk);
    vectors++;
    if (psel !== 8'h02 || penable !== 1'b0) begin
      miscompares++; $display("FAIL b2b_a_setup: got psel=%h penable=%b exp 02 0", psel, penable);
    end
    @(posedge hclk); #1;
    @(negedge hclk);
    vectors++;
    if (hready !== 1'b1 || hrdata !== 32'h1111_2222 || penable !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_a_done: got hready=%b hrdata=%h penable=%b exp 1 11112222 1", hready, hrdata, penable);
    end
    @(posedge hclk); #1; hsel = 1'b0; hwdata = 32'hCAFE_F00D;
    @(negedge hclk);
    vectors++;
    if (hready !== 1'b0 || psel !== '0 || penable !== 1'b0 || paddr !== 40'h00_1001_4010 || pwrite !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_b_wlatch: got hready=%b psel=%h penable=%b paddr=%h pwrite=%b exp 0 00 0 0010014010 1",
               hready, psel, penable, paddr, pwrite);
    end
    @(posedge hclk); #1;
    @(negedge hclk);
    vectors++;
    if (psel !== 8'h10 || penable !== 1'b0 || pwdata !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL b2b_b_setup: got psel=%h penable=%b pwdata=%h exp 10 0 cafef00d", psel, penable, pwdata);
    end
    @(posedge hclk); #1;
    @(negedge hclk);
    vectors++;
    if (hready !== 1'b1 || hresp !== 2'b00 || penable !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_b_done: got hready=%b hresp=%b penable=%b exp 1 00 1", hready, hresp, penable);
    end
  endtask

  task automatic test_reset_mid();
    wait_cfg = 20; err_cfg = 0;
    @(posedge hclk); #1; hsel = 1'b1; haddr = 40'h00_1001_4ABC; hwrite = 1'b0;
    @(posedge hclk); #1; hsel = 1'b0;
    @(posedge hclk); #1;
    @(negedge hclk);
    vectors++;
    if (penable !== 1'b1 || psel !== 8'h10) begin
      miscompares++; $display("FAIL reset_mid_access: got penable=%b psel=%h exp 1 10", penable, psel);
    end
    @(posedge hclk); #1; hrst = 1'b1;
    @(posedge hclk); #1; hrst = 1'b0;
    @(negedge hclk);
    vectors++;
    if ({psel, penable, paddr, pwrite, pwdata} !== '0 || {hready, hresp, hrdata} !== {1'b1, 2'b00, 32'h0}) begin
      miscompares++;
      $display("FAIL reset_mid: got psel=%h pen=%b paddr=%h pwrite=%b pwdata=%h hready=%b hresp=%b hrdata=%h exp reset values",
               psel, penable, paddr, pwrite, pwdata, hready, hresp, hrdata);
    end
    wait_cfg = 0;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    bit w, err;
    int waits, kind, s;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NSLV; i++) slv_rdata[i] = $urandom();
      kind = $urandom_range(0, 9);
      if (kind == 0)      a = {8'h00, 4'h2, 28'($urandom())};
      else if (kind == 1) a = {8'h00, 8'h1F, 24'($urandom())};
      else begin
        s = $urandom_range(0, 6);
        a = BASE[s] | AW'($urandom_range(0, 4095));
      end
      w     = 1'($urandom_range(0, 1));
      d     = $urandom();
      waits = $urandom_range(0, 5);
      err   = ($urandom_range(0, 5) == 0);
      model(a, w, waits, err);
      xfer(a, w, d, waits, err, 1'b0);
      vectors++;
      if (o_lat !== e_lat || o_errc !== e_errc || o_rdata !== e_rdata) begin
        miscompares++;
        $display("FAIL rand_ahb[%0d]: addr=%h w=%b waits=%0d err=%b got lat=%0d errc=%0d rdata=%h exp %0d %0d %h",
                 n, a, w, waits, err, o_lat, o_errc, o_rdata, e_lat, e_errc, e_rdata);
      end
      vectors++;
      if (o_psel_or !== e_psel || o_pen !== e_pen || o_pscyc !== e_pscyc || o_bad_sel) begin
        miscompares++;
        $display("FAIL rand_apb[%0d]: addr=%h got psel=%h pen=%0d pscyc=%0d badsel=%b exp %h %0d %0d 0",
                 n, a, o_psel_or, o_pen, o_pscyc, o_bad_sel, e_psel, e_pen, e_pscyc);
      end
      if (e_psel != '0) begin
        vectors++;
        if (o_paddr !== a || (w && o_pwdata !== d)) begin
          miscompares++;
          $display("FAIL rand_setup[%0d]: got paddr=%h pwdata=%h exp %h %h", n, o_paddr, o_pwdata, a, d);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, exp finish earlier");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hrst = 1'b1; hsel = 1'b0; haddr = '0; hwrite = 1'b0; hwdata = '0;
    wait_cfg = 0; err_cfg = 0;
    for (int i = 0; i < NSLV; i++) slv_rdata[i] = 32'hA5A5_0100 + DW'(i);
    test_reset();
    test_read();
    test_write_wait();
    test_unmapped();
    test_pslverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
